// File: rtl/score_scan.sv
// Multiplexed score display driver with blanking slots and win blink.
// Define SCORE_SEG7_EN to add a registered seven-segment output seg_o.
module score_scan #(
  parameter int NUM_DIGITS = 2,
  parameter int SCAN_DIV   = 1,
  parameter int BLINK_BITS = 10,
  parameter int WIN_SCORE  = 9
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [4*NUM_DIGITS-1:0] scores,
  output logic [3:0]              digit_o,
  output logic [NUM_DIGITS-1:0]   cath,
`ifdef SCORE_SEG7_EN
  output logic [6:0]              seg_o,
`endif
  output logic                    frame_o
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = $clog2(NUM_DIGITS);
  // A 5-bit threshold of 16 can never be reached by a 4-bit digit.
  localparam logic [4:0] WIN =
    (WIN_SCORE > 16) ? 5'd16 : 5'(WIN_SCORE);

  typedef enum logic {BLANK, SHOW} state_t;

  state_t                state;
  logic [PW-1:0]         pre;
  logic [IW-1:0]         idx;
  logic [BLINK_BITS-1:0] blink;
  logic                  on_q;
  logic                  tick;
  logic                  game_over;
  logic [3:0]            cur;

  assign tick = (pre == PW'(SCAN_DIV - 1));

  always_comb begin
    cur = '0;
    for (int k = 0; k < NUM_DIGITS; k++)
      if (idx == IW'(k))
        cur = scores[4*k +: 4];
  end

  always_comb begin
    game_over = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++)
      if ({1'b0, scores[4*k +: 4]} >= WIN)
        game_over = 1'b1;
  end

`ifdef SCORE_SEG7_EN
  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3f;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5b;
      4'd3:    s = 7'h4f;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6d;
      4'd6:    s = 7'h7d;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7f;
      4'd9:    s = 7'h6f;
      default: s = 7'h40;
    endcase
    return s;
  endfunction
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre     <= '0;
      state   <= BLANK;
      idx     <= '0;
      digit_o <= '0;
      frame_o <= 1'b0;
      blink   <= '0;
      on_q    <= 1'b1;
`ifdef SCORE_SEG7_EN
      seg_o   <= '0;
`endif
    end else begin
      blink   <= blink + BLINK_BITS'(1);
      on_q    <= !game_over || blink[BLINK_BITS-1];
      frame_o <= 1'b0;
      pre     <= tick ? '0 : pre + PW'(1);
      if (tick) begin
        unique case (state)
          BLANK: begin
            state   <= SHOW;
            digit_o <= cur;
`ifdef SCORE_SEG7_EN
            seg_o   <= seg7(cur);
`endif
          end
          SHOW: begin
            state <= BLANK;
            if (idx == IW'(NUM_DIGITS - 1)) begin
              idx     <= '0;
              frame_o <= 1'b1;
            end else begin
              idx <= idx + IW'(1);
            end
          end
        endcase
      end
    end
  end

  // Gate only the cathodes; the scan keeps running while blanked.
  assign cath = (state == SHOW && on_q)
              ? (NUM_DIGITS'(1) << idx) : '0;

endmodule

// File: tb/tb_score_scan.sv
// Scoreboard bench for score_scan: a 2-digit SCAN_DIV=4 instance
// and a 4-digit SCAN_DIV=1 instance sharing clock and reset.
module tb_score_scan;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  sa;
  logic [15:0] sb;
  logic [3:0]  dig_a, dig_b;
  logic [1:0]  cath_a;
  logic [3:0]  cath_b;
  logic        frame_a, frame_b;
`ifdef SCORE_SEG7_EN
  logic [6:0]  seg_a, seg_b;
`endif

  int errors = 0;
  int checks = 0;
  int cyc;

  typedef struct {
    int idx;
    int val;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  // Edges since reset release; also equals the DUT blink count.
  always @(posedge clk or negedge reset_n)
    if (!reset_n) cyc <= 0;
    else cyc <= cyc + 1;

  score_scan #(
    .NUM_DIGITS(2), .SCAN_DIV(4), .BLINK_BITS(4), .WIN_SCORE(9)
  ) dut_a (
    .clk(clk), .reset_n(reset_n), .scores(sa),
    .digit_o(dig_a), .cath(cath_a),
`ifdef SCORE_SEG7_EN
    .seg_o(seg_a),
`endif
    .frame_o(frame_a)
  );

  score_scan #(
    .NUM_DIGITS(4), .SCAN_DIV(1), .BLINK_BITS(10), .WIN_SCORE(9)
  ) dut_b (
    .clk(clk), .reset_n(reset_n), .scores(sb),
    .digit_o(dig_b), .cath(cath_b),
`ifdef SCORE_SEG7_EN
    .seg_o(seg_b),
`endif
    .frame_o(frame_b)
  );

  // Closed-form scan position after n edges: t ticks elapsed,
  // odd tick counts are SHOW slots, index advances every 2 ticks.
  function automatic logic [1:0] ecath_a(input int n);
    int t;
    t = n / 4;
    if (t % 2 == 0) return 2'b00;
    return ((t / 2) % 2 == 0) ? 2'b01 : 2'b10;
  endfunction

  function automatic logic efrm_a(input int n);
    return (n > 0) && (n % 16 == 0);
  endfunction

  function automatic logic [3:0] ecath_b(input int n);
    if (n % 2 == 0) return 4'b0000;
    return 4'b0001 << ((n / 2) % 4);
  endfunction

  function automatic logic efrm_b(input int n);
    return (n > 0) && (n % 8 == 0);
  endfunction

  task automatic test_reset;
    sa = 8'h35;
    sb = 16'h1234;
    #12;
    checks += 5;
    if (cath_a !== 2'b00) begin
      errors++; $display("FAIL rst_cath_a got=%b exp=00", cath_a);
    end
    if (dig_a !== 4'd0) begin
      errors++; $display("FAIL rst_dig_a got=%0d exp=0", dig_a);
    end
    if (frame_a !== 1'b0) begin
      errors++; $display("FAIL rst_frame_a got=%b exp=0", frame_a);
    end
    if (cath_b !== 4'b0000) begin
      errors++; $display("FAIL rst_cath_b got=%b exp=0000", cath_b);
    end
    if (dig_b !== 4'd0) begin
      errors++; $display("FAIL rst_dig_b got=%0d exp=0", dig_b);
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_scan;
    logic [1:0] prev;
    exp_t e;
    prev = cath_a;
    for (int i = 0; i < 5; i++)
      exp_q.push_back('{idx: i % 2, val: (i % 2 == 0) ? 5 : 3});
    while (cyc < 40) begin
      @(negedge clk);
      checks += 2;
      if (cath_a !== ecath_a(cyc)) begin
        errors++;
        $display("FAIL scan_cath n=%0d got=%b exp=%b",
                 cyc, cath_a, ecath_a(cyc));
      end
      if (frame_a !== efrm_a(cyc)) begin
        errors++;
        $display("FAIL scan_frame n=%0d got=%b exp=%b",
                 cyc, frame_a, efrm_a(cyc));
      end
      if (cath_a != 2'b00 && prev == 2'b00 && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks += 2;
        if (dig_a !== 4'(e.val)) begin
          errors++;
          $display("FAIL scan_digit n=%0d got=%0d exp=%0d",
                   cyc, dig_a, e.val);
        end
        if (cath_a !== (2'b01 << e.idx)) begin
          errors++;
          $display("FAIL scan_idx n=%0d got=%b exp_idx=%0d",
                   cyc, cath_a, e.idx);
        end
      end
      prev = cath_a;
    end
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL scan_queue left=%0d exp=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_midslot;
    logic [1:0] prev;
    exp_t e;
    bit found;
    exp_q.push_back('{idx: 0, val: 5});
    exp_q.push_back('{idx: 0, val: 7});
    for (int pass = 0; pass < 2; pass++) begin
      found = 0;
      prev = cath_a;
      for (int i = 0; i < 40 && !found; i++) begin
        @(negedge clk);
        if (cath_a == 2'b01 && prev != 2'b01) found = 1;
        prev = cath_a;
      end
      e = exp_q.pop_front();
      checks++;
      if (!found) begin
        errors++;
        $display("FAIL mid_wait pass=%0d got=timeout exp=slot", pass);
      end else if (dig_a !== 4'(e.val)) begin
        errors++;
        $display("FAIL mid_digit pass=%0d got=%0d exp=%0d",
                 pass, dig_a, e.val);
      end
      if (pass == 0) begin
        @(negedge clk);
        sa = 8'h37;
        while (cath_a == 2'b01) begin
          checks++;
          if (dig_a !== 4'd5) begin
            errors++;
            $display("FAIL mid_hold got=%0d exp=5", dig_a);
          end
          @(negedge clk);
        end
      end
    end
  endtask

  task automatic test_blink;
    int m, n;
    logic [1:0] raw, ex;
    @(negedge clk);
    m = cyc;
    sa = 8'h92;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      n = cyc;
      raw = ecath_a(n);
      ex = (((n - 1) % 16) >= 8) ? raw : 2'b00;
      checks++;
      if (cath_a !== ex) begin
        errors++;
        $display("FAIL blink_cath n=%0d got=%b exp=%b", n, cath_a, ex);
      end
      if (n >= m + 8 && raw != 2'b00) begin
        checks++;
        if (dig_a !== ((raw == 2'b01) ? 4'd2 : 4'd9)) begin
          errors++;
          $display("FAIL blink_digit n=%0d got=%0d exp=%0d",
                   n, dig_a, (raw == 2'b01) ? 2 : 9);
        end
      end
    end
  endtask

  task automatic test_reset_mid;
    bit found;
    sa = 8'h35;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (cath_a != 2'b00) found = 1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL rmid_wait got=timeout exp=show");
    end
    #1 reset_n = 1'b0;
    #1;
    checks += 3;
    if (cath_a !== 2'b00) begin
      errors++; $display("FAIL rmid_cath got=%b exp=00", cath_a);
    end
    if (dig_a !== 4'd0) begin
      errors++; $display("FAIL rmid_digit got=%0d exp=0", dig_a);
    end
    if (frame_a !== 1'b0) begin
      errors++; $display("FAIL rmid_frame got=%b exp=0", frame_a);
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      checks++;
      if (cath_a !== ecath_a(i)) begin
        errors++;
        $display("FAIL rmid_restart n=%0d got=%b exp=%b",
                 i, cath_a, ecath_a(i));
      end
      if (i == 4) begin
        checks++;
        if (dig_a !== 4'd5) begin
          errors++;
          $display("FAIL rmid_first got=%0d exp=5", dig_a);
        end
      end
    end
  endtask

  task automatic test_four_digit;
    int n;
    logic [3:0] ec;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      n = cyc;
      ec = ecath_b(n);
      checks += 2;
      if (cath_b !== ec) begin
        errors++;
        $display("FAIL four_cath n=%0d got=%b exp=%b", n, cath_b, ec);
      end
      if (frame_b !== efrm_b(n)) begin
        errors++;
        $display("FAIL four_frame n=%0d got=%b exp=%b",
                 n, frame_b, efrm_b(n));
      end
      if (ec != 4'b0000) begin
        checks++;
        if (dig_b !== 4'(4 - ((n / 2) % 4))) begin
          errors++;
          $display("FAIL four_digit n=%0d got=%0d exp=%0d",
                   n, dig_b, 4 - ((n / 2) % 4));
        end
      end
    end
  endtask

`ifdef SCORE_SEG7_EN
  task automatic test_seg7;
    logic [1:0] prev;
    bit found;
    logic [6:0] es;
    for (int pass = 0; pass < 2; pass++) begin
      sa = (pass == 0) ? 8'h38 : 8'h3c;
      es = (pass == 0) ? 7'b1111111 : 7'b1000000;
      found = 0;
      prev = cath_a;
      for (int i = 0; i < 40 && !found; i++) begin
        @(negedge clk);
        if (cath_a == 2'b01 && prev != 2'b01) found = 1;
        prev = cath_a;
      end
      checks++;
      if (!found) begin
        errors++;
        $display("FAIL seg_wait pass=%0d got=timeout exp=slot", pass);
      end else if (seg_a !== es) begin
        errors++;
        $display("FAIL seg_val pass=%0d got=%b exp=%b",
                 pass, seg_a, es);
      end
    end
  endtask
`endif

  initial begin
    test_reset;
    test_scan;
    test_midslot;
    test_blink;
    test_reset_mid;
    test_four_digit;
`ifdef SCORE_SEG7_EN
    test_seg7;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
